timer_peripheral: RTL and testbench

- Memory-mapped 32-bit up-counting timer with prescaler, compare match, and one-shot or periodic mode.
- Drives one active-low interrupt request line that connects directly to a timer bit of the interrupt controller's irq_sources input (bit 2 for instance 1, bit 3 for instance 2).
- Sits on the shared data bus alongside the interrupt controller and the other peripherals. Two instances are used, each with a distinct BASE_ADDR.

---
 rtl/timer_peripheral.sv | 138 +++++++++++++
 tb/tb_timer_peripheral.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_peripheral.sv
// Memory-mapped 32-bit up-counting timer: prescaler, compare match, one-shot
// or periodic mode, and an active-low level interrupt held until STATUS is cleared.
module timer_peripheral #(
  parameter logic [31:0] BASE_ADDR = 32'h4010
) (
  input  logic        clk,
  input  logic        reset,
  output logic        irq_n,
  inout  wire  [31:0] data_bus_data,
  input  logic [31:0] data_bus_addr,
  input  logic [1:0]  data_bus_mode
);

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_COMPARE  = 3'd2;
  localparam logic [2:0] OFF_COUNT    = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  logic        en_q, en_d;
  logic        periodic_q, periodic_d;
  logic        irq_en_q, irq_en_d;
  logic        match_q, match_d;
  logic [31:0] prescale_q, prescale_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pcnt_q, pcnt_d;

  logic [31:0] offset;
  logic        in_range;
  logic        rd_en, wr_en;
  logic        wr_ctrl, wr_prescale, wr_compare, wr_count, wr_status;
  logic        tick, hit;
  logic [31:0] rdata;

  // Unsigned distance from BASE_ADDR covers both bounds of the window at once.
  assign offset   = data_bus_addr - BASE_ADDR;
  assign in_range = (offset <= 32'd4);
  assign rd_en    = in_range && (data_bus_mode == 2'b01);
  assign wr_en    = in_range && (data_bus_mode == 2'b10);

  assign wr_ctrl     = wr_en && (offset[2:0] == OFF_CTRL);
  assign wr_prescale = wr_en && (offset[2:0] == OFF_PRESCALE);
  assign wr_compare  = wr_en && (offset[2:0] == OFF_COMPARE);
  assign wr_count    = wr_en && (offset[2:0] == OFF_COUNT);
  assign wr_status   = wr_en && (offset[2:0] == OFF_STATUS);

  assign tick  = en_q && (pcnt_q == prescale_q);
  // A software COUNT write on a tick edge suppresses match evaluation.
  assign hit   = tick && !wr_count && (count_q == compare_q);
  assign irq_n = ~(match_q & irq_en_q);

  always_comb begin
    case (offset[2:0])
      OFF_CTRL:     rdata = {29'd0, irq_en_q, periodic_q, en_q};
      OFF_PRESCALE: rdata = prescale_q;
      OFF_COMPARE:  rdata = compare_q;
      OFF_COUNT:    rdata = count_q;
      OFF_STATUS:   rdata = {31'd0, match_q};
      default:      rdata = 32'd0;
    endcase
  end

  assign data_bus_data = rd_en ? rdata : 32'bz;

  always_comb begin
    en_d       = en_q;
    periodic_d = periodic_q;
    irq_en_d   = irq_en_q;
    prescale_d = prescale_q;
    compare_d  = compare_q;
    count_d    = count_q;
    pcnt_d     = pcnt_q;

    if (en_q) begin
      pcnt_d = tick ? 32'd0 : pcnt_q + 32'd1;
    end

    if (tick && !wr_count) begin
      if (count_q == compare_q) begin
        if (periodic_q) begin
          count_d = 32'd0;
        end else begin
          en_d = 1'b0;
        end
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    // Set has priority over write-1-to-clear.
    match_d = hit || (match_q && !(wr_status && data_bus_data[0]));

    // Software writes are applied last so they win over tick side effects.
    if (wr_ctrl) begin
      en_d       = data_bus_data[0];
      periodic_d = data_bus_data[1];
      irq_en_d   = data_bus_data[2];
      if (!en_q && data_bus_data[0]) begin
        pcnt_d = 32'd0;
      end
    end
    if (wr_prescale) begin
      prescale_d = data_bus_data;
      pcnt_d     = 32'd0;
    end
    if (wr_compare) begin
      compare_d = data_bus_data;
    end
    if (wr_count) begin
      count_d = data_bus_data;
      pcnt_d  = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      irq_en_q   <= 1'b0;
      match_q    <= 1'b0;
      prescale_q <= 32'd0;
      compare_q  <= 32'd0;
      count_q    <= 32'd0;
      pcnt_q     <= 32'd0;
    end else begin
      en_q       <= en_d;
      periodic_q <= periodic_d;
      irq_en_q   <= irq_en_d;
      match_q    <= match_d;
      prescale_q <= prescale_d;
      compare_q  <= compare_d;
      count_q    <= count_d;
      pcnt_q     <= pcnt_d;
    end
  end

endmodule

// File: tb/tb_timer_peripheral.sv
// Bench for timer_peripheral: register vector table, hand-built timing sequences,
// and randomized bus traffic against a register-file level reference model.
module tb_timer_peripheral;

  localparam logic [31:0] BASE = 32'h4010;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq_n;
  wire  [31:0] data_bus_data;
  logic [31:0] addr;
  logic [1:0]  mode;
  logic [31:0] wdata;
  logic        tb_oe;

  assign data_bus_data = tb_oe ? wdata : 32'bz;

  timer_peripheral #(.BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .reset        (reset),
    .irq_n        (irq_n),
    .data_bus_data(data_bus_data),
    .data_bus_addr(addr),
    .data_bus_mode(mode)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_rd;
  logic        last_irq;

  // Reference model: the five visible registers as a small register file
  // (0 CTRL, 1 PRESCALE, 2 COMPARE, 3 COUNT, 4 STATUS) plus the tick phase.
  logic [31:0] mreg [0:4];
  logic [31:0] nreg [0:4];
  logic [31:0] mphase;
  logic [31:0] nphase;
  int          widx;
  logic        mwr, mtick, mset;

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) mreg[i] = 32'd0;
      mphase = 32'd0;
    end else begin
      for (int i = 0; i < 5; i++) nreg[i] = mreg[i];
      mwr   = (mode == 2'b10) && (addr >= BASE) && (addr <= BASE + 32'd4);
      widx  = int'(addr - BASE);
      mtick = mreg[0][0] && (mphase == mreg[1]);
      mset  = 1'b0;
      nphase = mreg[0][0] ? (mtick ? 32'd0 : mphase + 32'd1) : mphase;
      if (mtick && !(mwr && widx == 3)) begin
        if (mreg[3] == mreg[2]) begin
          mset = 1'b1;
          if (mreg[0][1]) nreg[3] = 32'd0;
          else nreg[0][0] = 1'b0;
        end else begin
          nreg[3] = mreg[3] + 32'd1;
        end
      end
      if (mwr) begin
        if (widx == 0) begin
          nreg[0] = wdata & 32'h7;
          if (!mreg[0][0] && wdata[0]) nphase = 32'd0;
        end else if (widx == 4) begin
          if (wdata[0]) nreg[4] = 32'd0;
        end else begin
          nreg[widx] = wdata;
          if (widx != 2) nphase = 32'd0;
        end
      end
      if (mset) nreg[4] = 32'd1;
      for (int i = 0; i < 5; i++) mreg[i] = nreg[i];
      mphase = nphase;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_undriven(input string name);
    checks++;
    if (!($isunknown(data_bus_data) || data_bus_data == 32'd0)) begin
      failures++;
      $display("FAIL %s: bus driven with %h, expected undriven", name, data_bus_data);
    end
  endtask

  // One bus cycle: drive, sample at the falling edge, then pass the rising edge.
  task automatic cyc(input logic [1:0] m, input logic [31:0] a, input logic [31:0] d);
    mode  = m;
    addr  = a;
    wdata = d;
    tb_oe = (m == 2'b10);
    @(negedge clk);
    last_rd  = data_bus_data;
    last_irq = irq_n;
    check("irq_n_model", {31'd0, irq_n}, {31'd0, ~(mreg[4][0] & mreg[0][2])});
    if (m == 2'b01) begin
      if (a >= BASE && a <= BASE + 32'd4) check("read_model", data_bus_data, mreg[int'(a - BASE)]);
      else check_undriven("read_out_of_range");
    end else if (m != 2'b10) begin
      check_undriven("bus_idle");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    cyc(2'b10, BASE + 32'(off), d);
  endtask

  task automatic rd(input int off);
    cyc(2'b01, BASE + 32'(off), 32'd0);
  endtask

  task automatic idle();
    cyc(2'b00, BASE, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    reset = 1'b1;
  endtask

  typedef struct {
    int          off;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, second, off, r;
    logic [31:0] d;

    vt[0] = '{1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vt[1] = '{2, 32'h1234_5678, 32'h1234_5678};
    vt[2] = '{3, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
    vt[3] = '{0, 32'hFFFF_FFFF, 32'h0000_0007};
    vt[4] = '{0, 32'h0000_0006, 32'h0000_0006};
    vt[5] = '{0, 32'h0000_0000, 32'h0000_0000};
    vt[6] = '{1, 32'h0000_0000, 32'h0000_0000};
    vt[7] = '{3, 32'h0000_0000, 32'h0000_0000};
    vt[8] = '{4, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[9] = '{2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    mode = 2'b00; addr = BASE; wdata = 32'd0; tb_oe = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset state
    for (int i = 0; i < 5; i++) begin
      rd(i);
      check("reset_reg", last_rd, 32'd0);
      check("reset_irq_n", {31'd0, last_irq}, 32'd1);
    end

    // Register write/readback table
    for (int i = 0; i < 10; i++) begin
      wr(vt[i].off, vt[i].wd);
      rd(vt[i].off);
      check($sformatf("vec%0d_readback", i), last_rd, vt[i].exp);
    end

    // Undriven bus outside reads and out-of-range writes ignored
    rd(5);
    cyc(2'b01, BASE - 32'd1, 32'd0);
    cyc(2'b00, BASE + 32'd2, 32'd0);
    check_undriven("idle_mode_00");
    cyc(2'b11, BASE + 32'd2, 32'd0);
    check_undriven("idle_mode_11");
    cyc(2'b10, BASE + 32'd5, 32'h7);
    cyc(2'b10, BASE - 32'd1, 32'h7);
    rd(0);
    check("oor_write_ctrl", last_rd, 32'd0);
    rd(2);
    check("oor_write_compare", last_rd, 32'hFFFF_FFFF);

    // Periodic timing: PRESCALE=3, COMPARE=4
    do_reset();
    wr(1, 3);
    wr(2, 4);
    wr(0, 7);
    first = -1;
    second = -1;
    for (int k = 0; k < 46; k++) begin
      if (k == 21) wr(4, 1);
      else rd(3);
      if (k == 3)  check("per_count_k3", last_rd, 32'd0);
      if (k == 4)  check("per_count_k4", last_rd, 32'd1);
      if (k == 19) check("per_count_k19", last_rd, 32'd4);
      if (k == 20) check("per_count_k20", last_rd, 32'd0);
      if (k == 22) check("per_irq_cleared", {31'd0, last_irq}, 32'd1);
      if (!last_irq && first < 0) first = k;
      else if (!last_irq && k > 22 && second < 0) second = k;
    end
    check("per_first_match", 32'(first), 32'd20);
    check("per_second_match", 32'(second), 32'd40);

    // One-shot: PRESCALE=0, COMPARE=2
    do_reset();
    wr(1, 0);
    wr(2, 2);
    wr(0, 5);
    first = -1;
    for (int k = 0; k < 8; k++) begin
      rd(3);
      if (k == 1) check("os_count_k1", last_rd, 32'd1);
      if (k >= 2) check("os_count_hold", last_rd, 32'd2);
      if (!last_irq && first < 0) first = k;
    end
    check("os_match_tick", 32'(first), 32'd3);
    rd(0);
    check("os_en_cleared", last_rd, 32'd4);
    check("os_irq_held", {31'd0, last_irq}, 32'd0);
    wr(4, 1);
    rd(4);
    check("os_status_cleared", last_rd, 32'd0);
    check("os_irq_released", {31'd0, last_irq}, 32'd1);

    // Set/clear collision on a tick edge
    do_reset();
    wr(1, 0);
    wr(2, 0);
    wr(0, 7);
    idle(); idle(); idle();
    wr(4, 1);
    rd(4);
    check("coll_match_kept", last_rd, 32'd1);
    check("coll_irq_low", {31'd0, last_irq}, 32'd0);
    wr(0, 3);
    rd(4);
    check("poll_match_no_irq", last_rd, 32'd1);
    check("poll_irq_high", {31'd0, last_irq}, 32'd1);

    // COUNT write on a matching tick edge wins and suppresses the match
    do_reset();
    wr(1, 0);
    wr(2, 3);
    wr(0, 7);
    idle(); idle(); idle();
    wr(3, 9);
    rd(4);
    check("cntwr_no_match", last_rd, 32'd0);
    rd(3);
    check("cntwr_value", last_rd, 32'd10);

    // CTRL write on a one-shot match edge wins
    do_reset();
    wr(1, 0);
    wr(2, 1);
    wr(0, 5);
    idle();
    wr(0, 7);
    rd(0);
    check("ctrlwr_wins", last_rd, 32'd7);
    check("ctrlwr_irq", {31'd0, last_irq}, 32'd0);
    rd(3);
    check("ctrlwr_periodic_reload", last_rd, 32'd0);

    // Wrap through zero without a match
    do_reset();
    wr(3, 32'hFFFF_FFFE);
    wr(2, 1);
    wr(1, 0);
    wr(0, 3);
    rd(3);
    check("wrap_k0", last_rd, 32'hFFFF_FFFE);
    rd(3);
    check("wrap_k1", last_rd, 32'hFFFF_FFFF);
    rd(4);
    check("wrap_no_match_at_zero", last_rd, 32'd0);
    rd(4);
    check("wrap_no_match_at_one", last_rd, 32'd0);
    rd(4);
    check("wrap_match", last_rd, 32'd1);

    // Reset mid-operation, with an asynchronous glitch first
    do_reset();
    wr(1, 0);
    wr(2, 3);
    wr(0, 7);
    for (int k = 0; k < 6; k++) idle();
    #2 reset = 1'b0;
    #1 reset = 1'b1;
    rd(4);
    check("glitch_match_kept", last_rd, 32'd1);
    rd(0);
    check("glitch_ctrl_kept", last_rd, 32'd7);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rd(i);
      check("midreset_reg", last_rd, 32'd0);
      check("midreset_irq_n", {31'd0, last_irq}, 32'd1);
    end
    for (int k = 0; k < 5; k++) idle();
    rd(3);
    check("midreset_no_ticks", last_rd, 32'd0);

    // Randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        do_reset();
      end else if (r < 40) begin
        off = int'($urandom_range(0, 7));
        if (off == 7) cyc(2'b01, BASE - 32'd1, 32'd0);
        else rd(off);
      end else if (r < 62) begin
        off = int'($urandom_range(0, 4));
        case (off)
          0: d = $urandom;
          1: d = $urandom_range(0, 3);
          2: d = $urandom_range(0, 6);
          3: d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                             : $urandom_range(0, 8);
          default: d = $urandom;
        endcase
        wr(off, d);
      end else begin
        idle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
